// File: rtl/prng_gen.sv
// ---------------------------------------------------------------------------
// prng_gen
//   Pseudo-random word generator. A DATA_W-bit XNOR LFSR supplies data bits,
//   and an OUT_W-bit (DATA_W/2) XNOR LFSR steers a bank of 2:1 bit selectors
//   that build the OUT_W-bit output word. A single-clock tick-enable divider
//   sets the free-run cadence. Seed loading, step, hold and burst modes are
//   supported.
//
// Ports
//   clk        : sole clock
//   rst_n      : synchronous active-low reset
//   ena        : design enable, low freezes all state
//   mode       : 00 free-run, 01 step, 10 hold, 11 burst
//   step       : level input, rising edge advances in step mode
//   seed_load  : load pulse for seed_in
//   seed_in    : seed for the data LFSR
//   out_data   : registered output word
//   out_valid  : one-cycle pulse when out_data changed due to an advance
// ---------------------------------------------------------------------------
module prng_gen #(
    parameter int DATA_W = 16,
    parameter int DIV    = 10_000_000
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                ena,
    input  logic [1:0]          mode,
    input  logic                step,
    input  logic                seed_load,
    input  logic [DATA_W-1:0]   seed_in,
    output logic [DATA_W/2-1:0] out_data,
    output logic                out_valid
);

    localparam int OUT_W  = DATA_W / 2;
    localparam int TCNT_W = 24;

    generate
        if (!(DATA_W == 8 || DATA_W == 16 || DATA_W == 24 || DATA_W == 32)) begin : g_bad_data_w
            $error("prng_gen: DATA_W must be 8, 16, 24 or 32");
        end
        if (DIV < 2 || DIV > (1 << 24)) begin : g_bad_div
            $error("prng_gen: DIV must be in 2..2^24");
        end
    endgenerate

    // Tap sets expressed as bit masks; feedback is the XNOR of the masked bits.
    function automatic logic [31:0] tap_mask(input int w);
        case (w)
            4:       return 32'h0000_000C; // 3,2
            8:       return 32'h0000_00B8; // 7,5,4,3
            12:      return 32'h0000_0829; // 11,5,3,0
            16:      return 32'h0000_D008; // 15,14,12,3
            24:      return 32'h00E1_0000; // 23,22,21,16
            32:      return 32'h8020_0003; // 31,21,1,0
            default: return 32'h0000_0000;
        endcase
    endfunction

    localparam logic [DATA_W-1:0] DMASK = DATA_W'(tap_mask(DATA_W));
    localparam logic [OUT_W-1:0]  CMASK = OUT_W'(tap_mask(OUT_W));
    localparam logic [TCNT_W-1:0] TMAX  = TCNT_W'(DIV - 1);

    function automatic logic [DATA_W-1:0] data_next(input logic [DATA_W-1:0] v);
        return {v[DATA_W-2:0], ~^(v & DMASK)};
    endfunction

    function automatic logic [OUT_W-1:0] ctrl_next(input logic [OUT_W-1:0] v);
        return {v[OUT_W-2:0], ~^(v & CMASK)};
    endfunction

    // Each output bit picks the odd or even bit of its data pair.
    function automatic logic [OUT_W-1:0] sel_map(input logic [DATA_W-1:0] d,
                                                 input logic [OUT_W-1:0]  c);
        logic [OUT_W-1:0] r;
        r = '0;
        for (int i = 0; i < OUT_W; i++) begin
            r[i] = c[i] ? d[2*i+1] : d[2*i];
        end
        return r;
    endfunction

    logic [TCNT_W-1:0] tcnt_q, tcnt_d;
    logic [1:0]        acnt_q, acnt_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic [OUT_W-1:0]  ctrl_q, ctrl_d;
    logic              step_d_q, step_d_d;
    logic [OUT_W-1:0]  out_q, out_d;
    logic              vld_q, vld_d;

    logic tick;
    logic step_rise;
    logic adv;

    assign tick      = (tcnt_q == TMAX);
    assign step_rise = step & ~step_d_q;

    always_comb begin
        adv = 1'b0;
        case (mode)
            2'b00:   adv = tick;
            2'b01:   adv = step_rise;
            2'b10:   adv = 1'b0;
            default: adv = 1'b1;
        endcase
    end

    always_comb begin
        tcnt_d   = tcnt_q;
        acnt_d   = acnt_q;
        data_d   = data_q;
        ctrl_d   = ctrl_q;
        step_d_d = step_d_q;
        out_d    = out_q;
        vld_d    = 1'b0;
        if (ena) begin
            tcnt_d   = tick ? '0 : tcnt_q + 1'b1;
            step_d_d = step;
            if (seed_load) begin
                // All-ones is the lock-up state, so it is never loaded.
                data_d = (&seed_in) ? '0 : seed_in;
                ctrl_d = '0;
                acnt_d = 2'd0;
                out_d  = sel_map(data_d, ctrl_d);
            end else if (adv) begin
                data_d = data_next(data_q);
                acnt_d = acnt_q + 2'd1;
                // Control steps on every fourth advance (acnt wrapping 3 -> 0).
                if (acnt_q == 2'd3) begin
                    ctrl_d = ctrl_next(ctrl_q);
                end
                out_d  = sel_map(data_d, ctrl_d);
                vld_d  = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            tcnt_q   <= '0;
            acnt_q   <= 2'd0;
            data_q   <= '0;
            ctrl_q   <= '0;
            step_d_q <= 1'b0;
            out_q    <= '0;
            vld_q    <= 1'b0;
        end else begin
            tcnt_q   <= tcnt_d;
            acnt_q   <= acnt_d;
            data_q   <= data_d;
            ctrl_q   <= ctrl_d;
            step_d_q <= step_d_d;
            out_q    <= out_d;
            vld_q    <= vld_d;
        end
    end

    assign out_data  = out_q;
    assign out_valid = vld_q;

endmodule

// File: tb/tb_prng_gen.sv
module tb_prng_gen;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        ena;
    logic [1:0]  mode;
    logic        step;
    logic        seed_load;
    logic [15:0] seed16;
    logic [7:0]  seed8;
    logic [7:0]  out16;
    logic        vld16;
    logic [3:0]  out8;
    logic        vld8;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    prng_gen #(.DATA_W(16), .DIV(4)) u16 (
        .clk(clk), .rst_n(rst_n), .ena(ena), .mode(mode), .step(step),
        .seed_load(seed_load), .seed_in(seed16), .out_data(out16), .out_valid(vld16)
    );

    prng_gen #(.DATA_W(8), .DIV(4)) u8 (
        .clk(clk), .rst_n(rst_n), .ena(ena), .mode(mode), .step(step),
        .seed_load(seed_load), .seed_in(seed8), .out_data(out8), .out_valid(vld8)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Inputs change on the falling edge; outputs are sampled there too.
    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        int pulses;
        int first;
        int p8, p16;
        logic ff8, ff16;
        logic [7:0] hold_out;

        rst_n = 1'b0; ena = 1'b1; mode = 2'b11; step = 1'b0;
        seed_load = 1'b0; seed16 = '0; seed8 = '0;
        cyc(3);
        chk("rst_out", 32'(out16), 32'h0);
        chk("rst_vld", 32'(vld16), 32'h0);
        chk("rst_data", 32'(u16.data_q), 32'h0);
        chk("rst_tcnt", 32'(u16.tcnt_q), 32'h0);

        // Burst from reset.
        rst_n = 1'b1;
        cyc(1);
        chk("b1_data", 32'(u16.data_q), 32'h0001);
        chk("b1_out", 32'(out16), 32'h01);
        chk("b1_vld", 32'(vld16), 32'h1);
        cyc(1);
        chk("b2_data", 32'(u16.data_q), 32'h0003);
        chk("b2_out", 32'(out16), 32'h01);
        chk("b2_vld", 32'(vld16), 32'h1);
        cyc(1);
        chk("b3_data", 32'(u16.data_q), 32'h0007);
        chk("b3_out", 32'(out16), 32'h03);
        chk("b3_ctrl", 32'(u16.ctrl_q), 32'h00);
        cyc(1);
        chk("b4_data", 32'(u16.data_q), 32'h000F);
        chk("b4_ctrl", 32'(u16.ctrl_q), 32'h01);
        chk("b4_out", 32'(out16), 32'h03);
        cyc(3);
        chk("b7_ctrl", 32'(u16.ctrl_q), 32'h01);
        chk("b7_vld", 32'(vld16), 32'h1);
        cyc(1);
        chk("b8_ctrl", 32'(u16.ctrl_q), 32'h03);

        // Hold: nothing moves for 100 cycles.
        mode = 2'b10;
        cyc(1);
        hold_out = out16;
        pulses = 0;
        for (int i = 0; i < 100; i++) begin
            cyc(1);
            if (vld16) pulses++;
        end
        chk("hold_pulses", 32'(pulses), 32'd0);
        chk("hold_out", 32'(out16), 32'(hold_out));

        // Step: one pulse per rising edge.
        mode = 2'b01; step = 1'b0;
        cyc(2);
        step = 1'b1;
        cyc(1);
        chk("step_lat", 32'(vld16), 32'h1);
        pulses = 1;
        for (int i = 0; i < 9; i++) begin
            cyc(1);
            if (vld16) pulses++;
        end
        chk("step_hold10", 32'(pulses), 32'd1);
        step = 1'b0;
        cyc(2);
        step = 1'b1;
        pulses = 0;
        for (int i = 0; i < 3; i++) begin
            cyc(1);
            if (vld16) pulses++;
        end
        chk("step_second", 32'(pulses), 32'd1);
        step = 1'b0;

        // Free-run, DIV=4: pulses after edges 4, 8, 12.
        rst_n = 1'b0; mode = 2'b00;
        cyc(2);
        rst_n = 1'b1;
        for (int k = 1; k <= 12; k++) begin
            cyc(1);
            chk($sformatf("fr_e%0d", k), 32'(vld16), ((k % 4) == 0) ? 32'h1 : 32'h0);
        end
        // Three disabled cycles push the next pulse from 4 to 7 edges out.
        first = 0;
        for (int k = 1; k <= 10; k++) begin
            ena = !(k >= 3 && k <= 5);
            cyc(1);
            if (vld16 && first == 0) first = k;
        end
        ena = 1'b1;
        chk("fr_ena_delay", 32'(first), 32'd7);

        // Seed loads (hold mode so no advance competes).
        mode = 2'b10;
        seed16 = 16'hACE1; seed_load = 1'b1;
        cyc(1);
        seed_load = 1'b0;
        chk("seed_data", 32'(u16.data_q), 32'hACE1);
        chk("seed_ctrl", 32'(u16.ctrl_q), 32'h0);
        chk("seed_out", 32'(out16), 32'h29);
        chk("seed_vld", 32'(vld16), 32'h0);
        seed16 = 16'hFFFF; seed_load = 1'b1;
        cyc(1);
        seed_load = 1'b0;
        chk("seed_ones", 32'(u16.data_q), 32'h0000);
        mode = 2'b11; seed16 = 16'h1234; seed_load = 1'b1;
        cyc(1);
        seed_load = 1'b0;
        chk("seed_prio_data", 32'(u16.data_q), 32'h1234);
        chk("seed_prio_vld", 32'(vld16), 32'h0);
        cyc(1);
        chk("seed_then_adv", 32'(u16.data_q), 32'h2468);
        chk("seed_then_vld", 32'(vld16), 32'h1);

        // Period in burst mode for both widths.
        rst_n = 1'b0; mode = 2'b11;
        cyc(2);
        rst_n = 1'b1;
        p8 = 0; p16 = 0; ff8 = 1'b0; ff16 = 1'b0;
        for (int n = 1; n <= 66000 && (p8 == 0 || p16 == 0); n++) begin
            cyc(1);
            if (u8.data_q == 8'hFF) ff8 = 1'b1;
            if (u16.data_q == 16'hFFFF) ff16 = 1'b1;
            if (p8 == 0 && u8.data_q == 8'h00) p8 = n;
            if (p16 == 0 && u16.data_q == 16'h0000) p16 = n;
        end
        chk("period8", 32'(p8), 32'd255);
        chk("never_ff8", 32'(ff8), 32'h0);
        chk("period16", 32'(p16), 32'd65535);
        chk("never_ffff16", 32'(ff16), 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
